// File: rtl/dec2bin.sv
// Two-digit BCD (tens, ones strobes) to 7-bit binary converter with one-cycle valid/error pulses.
// Optional build macro DEC2BIN_TIMEOUT_EN aborts a held tens digit after TIMEOUT_CYC idle cycles.
module dec2bin #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_digit,
  input  logic       i_tens,
  input  logic       i_ones,
  output logic [6:0] o_bin,
  output logic       o_valid,
  output logic       o_err,
  output logic       o_busy
);

  typedef enum logic {
    IDLE      = 1'b0,
    HAVE_TENS = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] tens_q, tens_d;
  logic [6:0] bin_d;
  logic       valid_d, err_d;
  logic       digit_ok;
  logic [6:0] tens_x10;
  logic       timeout_hit;

  assign digit_ok = (i_digit <= 4'd9);
  // tens*8 + tens*2 in 7 bits: max 90, exact for every legal digit.
  assign tens_x10 = {tens_q, 3'b000} + {2'b00, tens_q, 1'b0};
  assign o_busy   = (state_q == HAVE_TENS);

`ifdef DEC2BIN_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  assign timeout_hit = (cnt_q == 8'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC == 0);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    bin_d   = o_bin;
    valid_d = 1'b0;
    err_d   = 1'b0;
`ifdef DEC2BIN_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    if ((i_tens && i_ones) || ((i_tens || i_ones) && !digit_ok)) begin
      err_d   = 1'b1;
      state_d = IDLE;
      tens_d  = 4'd0;
    end else if (i_tens) begin
      tens_d  = i_digit;
      state_d = HAVE_TENS;
`ifdef DEC2BIN_TIMEOUT_EN
      cnt_d   = 8'd0;
`endif
    end else if (i_ones) begin
      bin_d   = (state_q == HAVE_TENS) ? tens_x10 + {3'b000, i_digit} : {3'b000, i_digit};
      valid_d = 1'b1;
      state_d = IDLE;
      tens_d  = 4'd0;
    end else if (state_q == HAVE_TENS) begin
      if (timeout_hit) begin
        err_d   = 1'b1;
        state_d = IDLE;
        tens_d  = 4'd0;
      end
`ifdef DEC2BIN_TIMEOUT_EN
      cnt_d = timeout_hit ? 8'd0 : cnt_q + 8'd1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tens_q  <= 4'd0;
      o_bin   <= 7'd0;
      o_valid <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      o_bin   <= bin_d;
      o_valid <= valid_d;
      o_err   <= err_d;
    end
  end

`ifdef DEC2BIN_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end
`endif

endmodule
